// File: rtl/signed_sat_add_arbiter.sv
// signed_sat_add_arbiter: one signed saturating adder shared by N_REQ requesters.
// The arbiter is round-robin, and each requester has a valid/ready handshake.
// The result register holds one entry and tags it with the requester id.
// Optional feature macro: SAT_ADD_ARB_SAT_FLAG_EN adds the res_sat clamp flag port.
module signed_sat_add_arbiter #(
    parameter int N_REQ = 4,
    parameter int W     = 4,
    localparam int IDW  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_vld,
    output logic [N_REQ-1:0]     req_rdy,
    input  logic [N_REQ*W-1:0]   req_a,
    input  logic [N_REQ*W-1:0]   req_b,
    output logic                 res_vld,
    input  logic                 res_rdy,
    output logic [W-1:0]         res_sum,
    output logic [IDW-1:0]       res_id
`ifdef SAT_ADD_ARB_SAT_FLAG_EN
    ,
    output logic                 res_sat
`endif
);

    localparam logic signed [W-1:0] SMAX = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0] SMIN = {1'b1, {(W-1){1'b0}}};

    // Sign-extend both operands to W+1 bits and add them; the sum clamps to the signed range.
    function automatic logic signed [W-1:0] sat_add(input logic signed [W-1:0] a,
                                                    input logic signed [W-1:0] b);
        logic signed [W:0] s;
        s = {a[W-1], a} + {b[W-1], b};
        if (s[W] != s[W-1])
            return s[W] ? SMIN : SMAX;
        else
            return s[W-1:0];
    endfunction

    // This is the overflow test from sat_add. A set flag means the sum was clamped.
    function automatic logic sat_ovf(input logic signed [W-1:0] a,
                                     input logic signed [W-1:0] b);
        logic signed [W:0] s;
        s = {a[W-1], a} + {b[W-1], b};
        return s[W] != s[W-1];
    endfunction

    logic [IDW-1:0]        ptr;
    logic                  free;
    logic [N_REQ-1:0]      gnt;
    logic [IDW-1:0]        gid;
    logic                  xfer;
    logic signed [W-1:0]   a_p0;
    logic signed [W-1:0]   b_p0;

    logic                  vld_p1;
    logic signed [W-1:0]   sum_p1;
    logic [IDW-1:0]        id_p1;
`ifdef SAT_ADD_ARB_SAT_FLAG_EN
    logic                  sat_p1;
`endif

    // ---- stage p0: arbitration and operand select (combinational) ----
    // The slot can be drained and refilled in the same cycle.
    // No grant is issued while reset is asserted.
    assign free = !vld_p1 || res_rdy;

    // Round-robin search starts at ptr and wraps. The first valid requester found wins.
    always_comb begin
        logic found;
        int   idx;
        gnt   = '0;
        gid   = '0;
        found = 1'b0;
        idx   = 0;
        if (rst && free) begin
            for (int k = 0; k < N_REQ; k++) begin
                idx = int'(ptr) + k;
                if (idx >= N_REQ)
                    idx = idx - N_REQ;
                if (!found && req_vld[idx]) begin
                    found    = 1'b1;
                    gnt[idx] = 1'b1;
                    gid      = idx[IDW-1:0];
                end
            end
        end
    end

    assign req_rdy = gnt;
    assign xfer    = |(gnt & req_vld);
    assign a_p0    = $signed(req_a[int'(gid)*W +: W]);
    assign b_p0    = $signed(req_b[int'(gid)*W +: W]);

    // ---- stage p1: result register and round-robin pointer ----
    // Capture the granted sum and move the pointer past the winner.
    // The register drains when the consumer takes the result and no new transfer arrives.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p1 <= 1'b0;
            sum_p1 <= '0;
            id_p1  <= '0;
            ptr    <= '0;
`ifdef SAT_ADD_ARB_SAT_FLAG_EN
            sat_p1 <= 1'b0;
`endif
        end else begin
            if (xfer) begin
                vld_p1 <= 1'b1;
                sum_p1 <= sat_add(a_p0, b_p0);
                id_p1  <= gid;
                ptr    <= (int'(gid) == N_REQ - 1) ? '0 : gid + 1'b1;
`ifdef SAT_ADD_ARB_SAT_FLAG_EN
                sat_p1 <= sat_ovf(a_p0, b_p0);
`endif
            end else if (res_rdy) begin
                vld_p1 <= 1'b0;
            end
        end
    end

    assign res_vld = vld_p1;
    assign res_sum = sum_p1;
    assign res_id  = id_p1;
`ifdef SAT_ADD_ARB_SAT_FLAG_EN
    assign res_sat = sat_p1;
`endif

endmodule

// File: tb/tb_signed_sat_add_arbiter.sv
// Directed testbench for signed_sat_add_arbiter with N_REQ=4 and W=4.
// Expected values are worked out by hand and written into the bench.
module tb_signed_sat_add_arbiter;

    localparam int N_REQ = 4;
    localparam int W     = 4;
    localparam int IDW   = 2;

    logic               clk;
    logic               rst;
    logic [N_REQ-1:0]   req_vld;
    logic [N_REQ-1:0]   req_rdy;
    logic [N_REQ*W-1:0] req_a;
    logic [N_REQ*W-1:0] req_b;
    logic               res_vld;
    logic               res_rdy;
    logic [W-1:0]       res_sum;
    logic [IDW-1:0]     res_id;
`ifdef SAT_ADD_ARB_SAT_FLAG_EN
    logic               res_sat;
`endif

    int errors = 0;
    int checks = 0;

    signed_sat_add_arbiter #(.N_REQ(N_REQ), .W(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .req_vld (req_vld),
        .req_rdy (req_rdy),
        .req_a   (req_a),
        .req_b   (req_b),
        .res_vld (res_vld),
        .res_rdy (res_rdy),
        .res_sum (res_sum),
        .res_id  (res_id)
`ifdef SAT_ADD_ARB_SAT_FLAG_EN
        ,
        .res_sat (res_sat)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Wait for the next rising edge, then move 1 ns past it before doing anything else.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
    endtask

    task automatic chk_res(input string tag, input logic [W-1:0] sum, input logic [IDW-1:0] id);
        chk({tag, "_vld"}, 32'(res_vld), 32'h1);
        chk({tag, "_sum"}, 32'(res_sum), 32'(sum));
        chk({tag, "_id"},  32'(res_id),  32'(id));
    endtask

    initial begin
        int order[4];
        rst     = 1'b0;
        req_vld = '1;
        req_a   = '0;
        req_b   = '0;
        res_rdy = 1'b1;

        // Reset state, with every req_vld raised during reset
        tick();
        tick();
        chk("rst_res_vld", 32'(res_vld), 32'h0);
        chk("rst_res_sum", 32'(res_sum), 32'h0);
        chk("rst_res_id",  32'(res_id),  32'h0);
        chk("rst_req_rdy", 32'(req_rdy), 32'h0);
`ifdef SAT_ADD_ARB_SAT_FLAG_EN
        chk("rst_res_sat", 32'(res_sat), 32'h0);
`endif
        req_vld = '0;
        rst     = 1'b1;
        tick();

        // Single transfers covering the normal, positive-clamp, negative-clamp and no-clamp cases
        set_ops(0, 4'h3, 4'hE);
        req_vld = 4'b0001;
        #1 chk("t1_rdy", 32'(req_rdy), 32'h1);
        tick();
        req_vld = '0;
        chk_res("t1", 4'h1, 2'd0);
`ifdef SAT_ADD_ARB_SAT_FLAG_EN
        chk("t1_sat", 32'(res_sat), 32'h0);
`endif
        set_ops(1, 4'h3, 4'h5);
        req_vld = 4'b0010;
        #1 chk("t2_rdy", 32'(req_rdy), 32'h2);
        tick();
        req_vld = '0;
        chk_res("t2", 4'h7, 2'd1);
`ifdef SAT_ADD_ARB_SAT_FLAG_EN
        chk("t2_sat", 32'(res_sat), 32'h1);
`endif
        set_ops(2, 4'hA, 4'hB);
        req_vld = 4'b0100;
        tick();
        req_vld = '0;
        chk_res("t3", 4'h8, 2'd2);
`ifdef SAT_ADD_ARB_SAT_FLAG_EN
        chk("t3_sat", 32'(res_sat), 32'h1);
`endif
        set_ops(3, 4'h8, 4'h7);
        req_vld = 4'b1000;
        tick();
        req_vld = '0;
        chk_res("t4", 4'hF, 2'd3);
`ifdef SAT_ADD_ARB_SAT_FLAG_EN
        chk("t4_sat", 32'(res_sat), 32'h0);
`endif
        // The result drains when nothing new arrives
        tick();
        chk("drain_vld", 32'(res_vld), 32'h0);

        // All four requesters valid: ids rotate 0,1,2,3,0,1,2,3
        for (int i = 0; i < N_REQ; i++) set_ops(i, 4'(i), 4'h1);
        req_vld = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            #1 chk("rr_rdy", 32'(req_rdy), 32'(1 << (k % 4)));
            tick();
            chk_res("rr", 4'((k % 4) + 1), 2'(k % 4));
        end
        req_vld = '0;
        tick();

        // One transfer from requester 0 leaves ptr at 1; then only 0 and 2 are valid
        req_vld = 4'b0001;
        tick();
        order = '{2, 0, 2, 0};
        req_vld = 4'b0101;
        for (int k = 0; k < 4; k++) begin
            #1 chk("sk_rdy", 32'(req_rdy), 32'(1 << order[k]));
            tick();
            chk_res("sk", 4'(order[k] + 1), 2'(order[k]));
        end
        // Requester 2 drops req_vld while ptr=2, so requester 3 is granted with no idle cycle
        req_vld = 4'b1110;
        tick();
        chk_res("dr1", 4'h2, 2'd1);
        req_vld = 4'b1010;
        tick();
        chk_res("dr2", 4'h4, 2'd3);
        req_vld = '0;
        tick();

        // Hold: res_rdy=0 for three cycles while all requesters are valid
        req_vld = 4'b0001;
        tick();
        res_rdy = 1'b0;
        req_vld = 4'b1111;
        for (int k = 0; k < 3; k++) begin
            #1 chk("hold_rdy", 32'(req_rdy), 32'h0);
            chk_res("hold", 4'h1, 2'd0);
            tick();
        end
        res_rdy = 1'b1;
        #1 chk("rel_rdy", 32'(req_rdy), 32'h2);
        tick();
        chk_res("rel", 4'h2, 2'd1);

        // Async reset asserted between clock edges
        #2 rst = 1'b0;
        #1;
        chk("arst_vld", 32'(res_vld), 32'h0);
        chk("arst_rdy", 32'(req_rdy), 32'h0);
        chk("arst_id",  32'(res_id),  32'h0);
        tick();
        rst = 1'b1;
        #1 chk("post_rdy", 32'(req_rdy), 32'h1);
        tick();
        chk_res("post", 4'h1, 2'd0);
        req_vld = '0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
